// File: rtl/efuse_arbiter.sv
// efuse_arbiter: round-robin arbiter sharing the eFuse controller port between two requesters,
// with write lock, illegal-op rejection and ack/done timeout.
module efuse_arbiter #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int TW          = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rq0_wr,
   input  logic        rq0_rd,
   input  logic [31:0] rq0_wdata,
   output logic        rq0_done,
   output logic        rq0_err,
   output logic [31:0] rq0_rdata,
   input  logic        rq1_wr,
   input  logic        rq1_rd,
   input  logic [31:0] rq1_wdata,
   output logic        rq1_done,
   output logic        rq1_err,
   output logic [31:0] rq1_rdata,
   input  logic        efuse_lock,
   output logic        wr,
   output logic        rd,
   output logic [31:0] data_write,
   input  logic [31:0] data_read,
   input  logic        ack,
   input  logic        wr_done,
   input  logic        rd_done,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, RESP} state_t;
   state_t        state_q, state_d;
   logic          id_q, id_d, pri_q, pri_d, opw_q, opw_d, opr_q, opr_d, err_q, err_d;
   logic [31:0]   wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [2:0]    hs_q, hs_p_q;
   logic          p0, p1, gnt, bad, tmo, ack_e, done_e;

   // controller pulses span several clk cycles: only their rising edges count
   assign ack_e  = hs_q[0] & ~hs_p_q[0];
   assign done_e = opw_q ? (hs_q[1] & ~hs_p_q[1]) : (hs_q[2] & ~hs_p_q[2]);
   assign p0     = rq0_wr | rq0_rd;
   assign p1     = rq1_wr | rq1_rd;
   assign gnt    = (p0 & p1) ? pri_q : p1;
   assign bad    = opw_q & (opr_q | efuse_lock);
   assign tmo    = cnt_q == TW'(TIMEOUT_CYC - 1);

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      pri_d    = pri_q;
      opw_d    = opw_q;
      opr_d    = opr_q;
      err_d    = err_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: if (p0 | p1) begin
            id_d    = gnt;
            opw_d   = gnt ? rq1_wr : rq0_wr;
            opr_d   = gnt ? rq1_rd : rq0_rd;
            wdata_d = gnt ? rq1_wdata : rq0_wdata;
            state_d = CHECK;
         end
         CHECK: begin
            cnt_d   = '0;
            err_d   = bad;
            state_d = bad ? RESP : REQ;
         end
         REQ: begin
            cnt_d = cnt_q + TW'(1);
            if (ack_e) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + TW'(1);
            if (done_e) begin
               rdata0_d = (opr_q & ~id_q) ? data_read : rdata0_q;
               rdata1_d = (opr_q & id_q) ? data_read : rdata1_q;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            pri_d   = ~id_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         id_q     <= 1'b0;
         pri_q    <= 1'b0;
         opw_q    <= 1'b0;
         opr_q    <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         cnt_q    <= '0;
         hs_q     <= '0;
         hs_p_q   <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         pri_q    <= pri_d;
         opw_q    <= opw_d;
         opr_q    <= opr_d;
         err_q    <= err_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         cnt_q    <= cnt_d;
         hs_q     <= {rd_done, wr_done, ack};
         hs_p_q   <= hs_q;
      end
   end

   assign busy       = state_q != IDLE;
   assign wr         = (state_q == REQ) & opw_q;
   assign rd         = (state_q == REQ) & opr_q;
   assign data_write = wdata_q;
   assign rq0_done   = (state_q == RESP) & ~id_q;
   assign rq1_done   = (state_q == RESP) & id_q;
   assign rq0_err    = rq0_done & err_q;
   assign rq1_err    = rq1_done & err_q;
   assign rq0_rdata  = rdata0_q;
   assign rq1_rdata  = rdata1_q;
endmodule

// File: tb/tb_efuse_arbiter.sv
// tb_efuse_arbiter: directed stimulus with scoreboarded responses and controller strobes
// for efuse_arbiter, plus a reactive eFuse controller model.
module tb_efuse_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        rq0_wr = 1'b0, rq0_rd = 1'b0, rq1_wr = 1'b0, rq1_rd = 1'b0, efuse_lock = 1'b0;
   logic [31:0] rq0_wdata = '0, rq1_wdata = '0, data_read = '0;
   logic        ack, wr_done, rd_done;
   logic        rq0_done, rq0_err, rq1_done, rq1_err, wr, rd, busy;
   logic [31:0] rq0_rdata, rq1_rdata, data_write;

   typedef struct packed {logic id; logic err; logic chk; logic [31:0] rdata;} rsp_t;
   typedef struct packed {logic w; logic [31:0] d; logic [7:0] width;} stb_t;
   rsp_t rsp_q[$];
   stb_t stb_q[$];
   rsp_t re;
   stb_t se;
   logic se_v = 1'b0, stb_p = 1'b0;
   int   stb_w = 0;
   int   n_cmp = 0, n_err = 0;
   int   ack_dly = 0, ack_w = 1, done_dly = 0, done_w = 1, mute = 0;
   int   ph = 0, tm = 0, cnt = 0, n_hi = 0;
   logic cw = 1'b0;

   efuse_arbiter #(.TIMEOUT_CYC(16), .TW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .rq0_wr(rq0_wr), .rq0_rd(rq0_rd), .rq0_wdata(rq0_wdata),
      .rq0_done(rq0_done), .rq0_err(rq0_err), .rq0_rdata(rq0_rdata),
      .rq1_wr(rq1_wr), .rq1_rd(rq1_rd), .rq1_wdata(rq1_wdata),
      .rq1_done(rq1_done), .rq1_err(rq1_err), .rq1_rdata(rq1_rdata),
      .efuse_lock(efuse_lock), .wr(wr), .rd(rd), .data_write(data_write),
      .data_read(data_read), .ack(ack), .wr_done(wr_done), .rd_done(rd_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic id, input logic w, input logic r, input logic [31:0] d);
      if (id) begin
         rq1_wr = w; rq1_rd = r; rq1_wdata = d;
      end else begin
         rq0_wr = w; rq0_rd = r; rq0_wdata = d;
      end
   endtask

   task automatic wait_done(input logic id);
      bit seen = 0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         seen = id ? rq1_done : rq0_done;
      end
      chk("done_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      set_req(id, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic access(input logic id, input logic w, input logic r, input logic [31:0] d,
                         input logic err, input logic [31:0] rdat, input int width);
      if (width > 0) stb_q.push_back('{w: w, d: d, width: 8'(width)});
      rsp_q.push_back('{id: id, err: err, chk: r & ~err, rdata: rdat});
      @(posedge clk); #1;
      set_req(id, w, r, d);
      wait_done(id);
   endtask

   // controller model: acks each strobe, then pulses the matching done
   initial begin
      ack = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            ph = 0; ack = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
         end else if (ph == 0) begin
            if ((wr | rd) && mute == 0) begin cw = wr; tm = ack_dly; ph = 1; end
         end else if (ph == 1) begin
            if (tm > 0) tm--; else begin ack = 1'b1; tm = ack_w - 1; ph = 2; end
         end else if (ph == 2) begin
            if (tm > 0) tm--; else begin ack = 1'b0; tm = done_dly; ph = 3; end
         end else if (ph == 3) begin
            if (tm > 0) tm--;
            else begin
               if (cw) wr_done = 1'b1; else rd_done = 1'b1;
               tm = done_w - 1; ph = 4;
            end
         end else begin
            if (tm > 0) tm--; else begin wr_done = 1'b0; rd_done = 1'b0; ph = 0; end
         end
      end
   end

   // response monitor
   initial forever begin
      @(negedge clk);
      if (rq0_done | rq1_done) begin
         if (rsp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got rq0_done=%0b rq1_done=%0b expected none", rq0_done, rq1_done);
         end else begin
            re = rsp_q.pop_front();
            chk("done_id", 32'({rq1_done, rq0_done}), re.id ? 32'd2 : 32'd1);
            chk("done_err", 32'(re.id ? rq1_err : rq0_err), 32'(re.err));
            if (re.chk) chk("rdata", re.id ? rq1_rdata : rq0_rdata, re.rdata);
         end
      end
   end

   // controller strobe monitor
   initial forever begin
      @(negedge clk);
      if ((wr | rd) && !stb_p) begin
         stb_w = 0;
         if (stb_q.size() == 0) begin
            n_cmp++; n_err++; se_v = 1'b0;
            $display("FAIL unexpected_strobe: got wr=%0b rd=%0b data_write=%h expected none", wr, rd, data_write);
         end else begin
            se = stb_q.pop_front(); se_v = 1'b1;
            chk("strobe_op", 32'({wr, rd}), se.w ? 32'd2 : 32'd1);
            chk("data_write", data_write, se.d);
         end
      end
      if (wr | rd) stb_w++;
      else if (stb_p && se_v) begin
         chk("strobe_width", 32'(stb_w), 32'(se.width));
         se_v = 1'b0;
      end
      stb_p = wr | rd;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_strobes", 32'({wr, rd, busy}), 32'd0);
      chk("rst_done", 32'({rq0_done, rq0_err, rq1_done, rq1_err}), 32'd0);
      chk("rst_data_write", data_write, 32'd0);
      chk("rst_rdata", rq0_rdata | rq1_rdata, 32'd0);
      rst_n = 1'b1;

      // both write continuously: grants alternate starting at rq0
      stb_q.push_back('{w: 1'b1, d: 32'h1111_1111, width: 8'd3});
      stb_q.push_back('{w: 1'b1, d: 32'h2222_2222, width: 8'd3});
      stb_q.push_back('{w: 1'b1, d: 32'h1111_1111, width: 8'd3});
      stb_q.push_back('{w: 1'b1, d: 32'h2222_2222, width: 8'd3});
      rsp_q.push_back('{id: 1'b0, err: 1'b0, chk: 1'b0, rdata: 32'd0});
      rsp_q.push_back('{id: 1'b1, err: 1'b0, chk: 1'b0, rdata: 32'd0});
      rsp_q.push_back('{id: 1'b0, err: 1'b0, chk: 1'b0, rdata: 32'd0});
      rsp_q.push_back('{id: 1'b1, err: 1'b0, chk: 1'b0, rdata: 32'd0});
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b0, 32'h1111_1111);
      set_req(1'b1, 1'b1, 1'b0, 32'h2222_2222);
      cnt = 0;
      for (int n = 0; n < 200 && cnt < 4; n++) begin
         @(negedge clk);
         if (rq0_done | rq1_done) cnt++;
      end
      chk("b2b_count", 32'(cnt), 32'd4);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 32'd0);
      set_req(1'b1, 1'b0, 1'b0, 32'd0);

      // rq0 read: ack at +3, rd_done at +10
      ack_dly = 2; done_dly = 5; data_read = 32'hA5A5_1234;
      access(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'hA5A5_1234, 5);
      ack_dly = 0; done_dly = 0;

      // locked write refused at cycle 2 with no strobe
      efuse_lock = 1'b1;
      rsp_q.push_back('{id: 1'b1, err: 1'b1, chk: 1'b0, rdata: 32'd0});
      @(posedge clk); #1;
      set_req(1'b1, 1'b1, 1'b0, 32'h3333_3333);
      @(posedge clk); #1;
      chk("lock_cyc1_done", 32'(rq1_done), 32'd0);
      @(posedge clk); #1;
      chk("lock_cyc2_done_err", 32'({rq1_done, rq1_err}), 32'd3);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 1'b0, 32'd0);
      data_read = 32'h5EED_0001;
      access(1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'h5EED_0001, 3);
      efuse_lock = 1'b0;

      // controller never acks: 16 strobe cycles, then err, then idle
      mute = 1;
      stb_q.push_back('{w: 1'b1, d: 32'hDEAD_0001, width: 8'd16});
      rsp_q.push_back('{id: 1'b0, err: 1'b1, chk: 1'b0, rdata: 32'd0});
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b0, 32'hDEAD_0001);
      for (int n = 0; n < 10 && !wr; n++) begin @(posedge clk); #1; end
      n_hi = 0;
      for (int n = 0; n < 50 && wr; n++) begin n_hi++; @(posedge clk); #1; end
      chk("timeout_strobe_cycles", 32'(n_hi), 32'd16);
      chk("timeout_done_err", 32'({rq0_done, rq0_err}), 32'd3);
      @(posedge clk); #1;
      chk("timeout_busy_after", 32'(busy), 32'd0);
      set_req(1'b0, 1'b0, 1'b0, 32'd0);
      mute = 0;

      // illegal wr+rd, then 2-cycle-wide acks
      access(1'b0, 1'b1, 1'b1, 32'h4444_4444, 1'b1, 32'd0, 0);
      ack_w = 2;
      access(1'b0, 1'b1, 1'b0, 32'hCAFE_0002, 1'b0, 32'd0, 3);
      data_read = 32'h1357_9BDF;
      access(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h1357_9BDF, 3);
      ack_w = 1;

      // reset while in WAIT; request is re-granted afterwards
      done_dly = 20; data_read = 32'h1111_2222;
      stb_q.push_back('{w: 1'b0, d: 32'd0, width: 8'd3});
      stb_q.push_back('{w: 1'b0, d: 32'd0, width: 8'd3});
      rsp_q.push_back('{id: 1'b0, err: 1'b0, chk: 1'b1, rdata: 32'h2468_ACE0});
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b1, 32'd0);
      for (int n = 0; n < 20 && !(wr | rd); n++) begin @(posedge clk); #1; end
      for (int n = 0; n < 20 && (wr | rd); n++) begin @(posedge clk); #1; end
      repeat (2) begin @(posedge clk); #1; end
      chk("wait_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_strobes", 32'({wr, rd, busy}), 32'd0);
      chk("arst_done", 32'({rq0_done, rq0_err, rq1_done, rq1_err}), 32'd0);
      chk("arst_data_write", data_write, 32'd0);
      chk("arst_rdata", rq0_rdata | rq1_rdata, 32'd0);
      repeat (2) @(posedge clk);
      done_dly = 0; data_read = 32'h2468_ACE0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(1'b0);

      repeat (5) @(posedge clk);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      chk("stb_q_empty", 32'(stb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/efuse_arbiter.md
# efuse_arbiter

Shares the single eFuse macro port (the `efuse_controller` wr/rd/ack/wr_done/rd_done handshake) between two requesters. Requester 0 is the power-up/auto-load sequencer; requester 1 is the I2C register path. The block runs round-robin arbitration and sequences one 32-bit access at a time. It also enforces a write lock and aborts accesses that never complete, returning an error to the requester.

## Interface
Parameters:
- `TIMEOUT_CYC`, 4096: clk cycles allowed from access start to the ack edge, and again from the ack edge to the done edge, before abort.
- `TW`, 13: width of the timeout counter; must hold `TIMEOUT_CYC`.

Ports:
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `rq0_wr`, `rq0_rd` input 1 each: requester 0 level requests, held until `rq0_done`.
- `rq0_wdata` input 32: requester 0 write data, stable while requesting.
- `rq0_done` output 1: one-cycle completion pulse.
- `rq0_err` output 1: qualifies `rq0_done`; high means the access failed.
- `rq0_rdata` output 32: read data, valid from `rq0_done` until the next access.
- `rq1_wr`, `rq1_rd`, `rq1_wdata`, `rq1_done`, `rq1_err`, `rq1_rdata`: same as requester 0, for requester 1.
- `efuse_lock` input 1: when 1, all writes are refused.
- `wr` output 1: write strobe to the controller.
- `rd` output 1: read strobe to the controller.
- `data_write` output 32: write data to the controller.
- `data_read` input 32: read data from the controller.
- `ack`, `wr_done`, `rd_done` input 1 each: controller handshake. The controller runs on the divided clock, so each pulse is 1 or more clk cycles wide.
- `busy` output 1: high in every state except IDLE.

## Operation
- Reset values:
  - `wr`, `rd`, `busy`: 0.
  - `rqN_done`, `rqN_err`: 0.
  - `data_write`, `rqN_rdata`: 0.
  - State: IDLE. Round-robin pointer: requester 0 first.
- Edge detect: `ack`, `wr_done`, `rd_done` are each registered once. A rising edge is the current sample 1 with the previous sample 0. Only rising edges are acted on.
- FSM states: IDLE, CHECK, REQ, WAIT, RESP.
- IDLE:
  - A requester is pending when its `wr` or `rd` is high.
  - If both requesters are pending, the grant goes to the one not served last.
  - On grant, latch the requester id, the op, and the wdata, then go to CHECK.
- CHECK (1 cycle), error checks:
  - `wr` and `rd` both high: error.
  - Write with `efuse_lock` = 1: error.
  - On error go to RESP with err=1; the controller is never touched.
  - Otherwise go to REQ.
- REQ:
  - Drive `wr` or `rd` high and `data_write` = latched wdata.
  - On the ack rising edge, drop the strobe, clear the timeout counter, go to WAIT.
- WAIT:
  - Wait for the matching done edge: `wr_done` for writes, `rd_done` for reads.
  - On a read completion, capture `data_read` into the granted `rqN_rdata`.
  - Then go to RESP with err=0.
  - A done edge for the wrong op is ignored.
- Timeout:
  - The counter increments every cycle in REQ and WAIT.
  - When it reaches `TIMEOUT_CYC - 1`, drop `wr`/`rd` and go to RESP with err=1.
- RESP (1 cycle):
  - Pulse `done` and `err` to the granted requester only.
  - Toggle the round-robin pointer to favour the other requester.
  - Return to IDLE.
- Requester contract: drop its request in the cycle after `done`. The FSM resamples requests only in IDLE, so a request still held there is treated as a new access.
- A request that arrives or drops while another access is in progress is ignored until IDLE. A requester that drops its request while granted still receives `done`.

## Timing
- Request high at cycle 0, unit idle:
  - cycle 1: CHECK.
  - cycle 2: strobe high.
- Ack rising at cycle k: the strobe is low at cycle k+2, because of the sampling register.
- Done rising at cycle m:
  - cycle m+2: `rdata` updated, state RESP, `done` high.
  - cycle m+3: IDLE.
- Minimum turnaround, request to `done`, with the controller ack-ing immediately: 7 cycles.
- Error path (lock or illegal op): `done` + `err` at cycle 2.
- Back-to-back: with both requesters continuously pending, grants alternate 0,1,0,1.
- `rst_n` low mid-access:
  - All outputs return to reset values immediately.
  - No `done` is issued.
  - The controller sees the strobe drop asynchronously.

## Test plan
- Read by rq0, controller returns ack at +3 and `rd_done` at +10 with `data_read` = 0xA5A5_1234 -> `rq0_done` = 1, `rq0_err` = 0, `rq0_rdata` = 0xA5A5_1234, `rq1_done` stays 0.
- Both requesters assert writes in the same cycle (0x1111_1111 on rq0, 0x2222_2222 on rq1) and hold them, re-asserting after each done -> the controller sees rq0's data first, then rq1's, alternating, and `data_write` matches each grant.
- `efuse_lock` = 1 with `rq1_wr` -> `rq1_done` + `rq1_err` at cycle 2, `wr` never asserted. A following `rq1_rd` still succeeds.
- Controller never acks, `TIMEOUT_CYC` = 16 -> strobe drops after 16 REQ cycles, then `done` + `err` to the requester and `busy` = 0 on the next cycle.
- `rq0_wr` and `rq0_rd` high together -> error response with no controller strobe. A 2-cycle-wide ack produces exactly one state advance.
- `rst_n` pulsed low while in WAIT -> all outputs 0 and state IDLE. The pending request is re-granted after reset and completes normally.
